// File: rtl/paddle_controller.sv
// Two-player paddle position controller: frame-tick movement, clamping, goal freeze.
// Build macro PADDLE_ACCEL_EN enables per-axis hold acceleration (default: fixed step).
module paddle_controller (
    input  logic       clk,
    input  logic       clr,
    input  logic       prev_clk_cursor,
    input  logic       clk_cursor,
    input  logic [3:0] btn1,
    input  logic [3:0] btn2,
    input  logic       goal1,
    input  logic       goal2,
    output logic [9:0] ball1_x,
    output logic [9:0] ball1_y,
    output logic [9:0] ball2_x,
    output logic [9:0] ball2_y,
    output logic       frozen
);

    localparam int unsigned PW = 10;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 5;

    localparam int unsigned B_UP = 3;
    localparam int unsigned B_DN = 2;
    localparam int unsigned B_LT = 1;
    localparam int unsigned B_RT = 0;

    localparam logic [PW-1:0] P1_X_MIN  = 10'd249;
    localparam logic [PW-1:0] P1_X_MAX  = 10'd449;
    localparam logic [PW-1:0] P2_X_MIN  = 10'd479;
    localparam logic [PW-1:0] P2_X_MAX  = 10'd679;
    localparam logic [PW-1:0] Y_MIN     = 10'd126;
    localparam logic [PW-1:0] Y_MAX     = 10'd416;
    localparam logic [PW-1:0] P1_HOME_X = 10'd289;
    localparam logic [PW-1:0] P2_HOME_X = 10'd639;
    localparam logic [PW-1:0] HOME_Y    = 10'd271;

    localparam logic [CW-1:0] FREEZE_LOAD = 5'd31;

    typedef enum logic {PLAY, FREEZE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] p1x_nxt, p1y_nxt, p2x_nxt, p2y_nxt;

    logic [3:0] b1_meta, b1_sync, b2_meta, b2_sync;
    logic       goal_d;
    logic       tick, goal_evt;
    logic [SW-1:0] step1x, step1y, step2x, step2y;

    assign tick     = !prev_clk_cursor && clk_cursor;
    assign goal_evt = (goal1 || goal2) && !goal_d;

    // One axis update; 11-bit signed intermediate keeps underflow from wrapping before the clamp.
    function automatic logic [PW-1:0] axis_step(
        input logic [PW-1:0] pos,
        input logic          dec,
        input logic          inc,
        input logic [SW-1:0] step,
        input logic [PW-1:0] lo,
        input logic [PW-1:0] hi
    );
        logic signed [PW:0] t;
        logic signed [PW:0] s;
        t = $signed({1'b0, pos});
        s = $signed({{(PW+1-SW){1'b0}}, step});
        if (inc && !dec)
            t = t + s;
        else if (dec && !inc)
            t = t - s;
        if (t < $signed({1'b0, lo}))
            axis_step = lo;
        else if (t > $signed({1'b0, hi}))
            axis_step = hi;
        else
            axis_step = t[PW-1:0];
    endfunction

    // Button synchronizers and goal edge detector.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            b1_meta <= '0;
            b1_sync <= '0;
            b2_meta <= '0;
            b2_sync <= '0;
            goal_d  <= 1'b0;
        end else begin
            b1_meta <= btn1;
            b1_sync <= b1_meta;
            b2_meta <= btn2;
            b2_sync <= b2_meta;
            goal_d  <= goal1 || goal2;
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int unsigned   HW       = 6;
    localparam logic [HW-1:0] HOLD_SAT = 6'd48;

    logic [HW-1:0] hold1x, hold1y, hold2x, hold2y;

    function automatic logic [SW-1:0] hold_step(input logic [HW-1:0] h);
        if (h >= HOLD_SAT)
            hold_step = 4'd8;
        else
            hold_step = 4'd2 + SW'(h[HW-1:3]);
    endfunction

    function automatic logic [HW-1:0] hold_next(input logic [HW-1:0] h, input logic pressed);
        if (!pressed)
            hold_next = '0;
        else if (h >= HOLD_SAT)
            hold_next = HOLD_SAT;
        else
            hold_next = h + HW'(1);
    endfunction

    // Consecutive pressed-tick counters; cleared on release and whenever play stops.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold1x <= '0;
            hold1y <= '0;
            hold2x <= '0;
            hold2y <= '0;
        end else if (goal_evt || state != PLAY) begin
            hold1x <= '0;
            hold1y <= '0;
            hold2x <= '0;
            hold2y <= '0;
        end else if (tick) begin
            hold1x <= hold_next(hold1x, b1_sync[B_LT] ^ b1_sync[B_RT]);
            hold1y <= hold_next(hold1y, b1_sync[B_UP] ^ b1_sync[B_DN]);
            hold2x <= hold_next(hold2x, b2_sync[B_LT] ^ b2_sync[B_RT]);
            hold2y <= hold_next(hold2y, b2_sync[B_UP] ^ b2_sync[B_DN]);
        end
    end

    assign step1x = hold_step(hold1x);
    assign step1y = hold_step(hold1y);
    assign step2x = hold_step(hold2x);
    assign step2y = hold_step(hold2y);
`else
    localparam logic [SW-1:0] STEP_DEF = 4'd4;

    assign step1x = STEP_DEF;
    assign step1y = STEP_DEF;
    assign step2x = STEP_DEF;
    assign step2y = STEP_DEF;
`endif

    // State, freeze counter and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= PLAY;
            cnt     <= '0;
            ball1_x <= P1_HOME_X;
            ball1_y <= HOME_Y;
            ball2_x <= P2_HOME_X;
            ball2_y <= HOME_Y;
            frozen  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ball1_x <= p1x_nxt;
            ball1_y <= p1y_nxt;
            ball2_x <= p2x_nxt;
            ball2_y <= p2y_nxt;
            frozen  <= (state_nxt == FREEZE);
        end
    end

    // Next state; a goal event overrides any movement or countdown in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p1x_nxt   = ball1_x;
        p1y_nxt   = ball1_y;
        p2x_nxt   = ball2_x;
        p2y_nxt   = ball2_y;
        if (goal_evt) begin
            state_nxt = FREEZE;
            cnt_nxt   = FREEZE_LOAD;
            p1x_nxt   = P1_HOME_X;
            p1y_nxt   = HOME_Y;
            p2x_nxt   = P2_HOME_X;
            p2y_nxt   = HOME_Y;
        end else begin
            case (state)
                PLAY: begin
                    if (tick) begin
                        p1x_nxt = axis_step(ball1_x, b1_sync[B_LT], b1_sync[B_RT], step1x, P1_X_MIN, P1_X_MAX);
                        p1y_nxt = axis_step(ball1_y, b1_sync[B_UP], b1_sync[B_DN], step1y, Y_MIN, Y_MAX);
                        p2x_nxt = axis_step(ball2_x, b2_sync[B_LT], b2_sync[B_RT], step2x, P2_X_MIN, P2_X_MAX);
                        p2y_nxt = axis_step(ball2_y, b2_sync[B_UP], b2_sync[B_DN], step2y, Y_MIN, Y_MAX);
                    end
                end
                FREEZE: begin
                    if (tick) begin
                        if (cnt == '0)
                            state_nxt = PLAY;
                        else
                            cnt_nxt = cnt - CW'(1);
                    end
                end
                default: state_nxt = PLAY;
            endcase
        end
    end

endmodule

// File: doc/paddle_controller.md
PADDLE_CONTROLLER -- requirements
Module: paddle_controller

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 clr  in  1  reset, asynchronous, active-high.
REQ-003 prev_clk_cursor  in  1  frame-tick level, previous sample.
REQ-004 clk_cursor  in  1  frame-tick level, current sample; tick = prev_clk_cursor==0 && clk_cursor==1.
REQ-005 btn1  in  4  player-1 buttons {up,down,left,right} = bits [3:0], asynchronous, active-high.
REQ-006 btn2  in  4  player-2 buttons, same bit order as btn1.
REQ-007 goal1  in  1  goal flag for player-1 side, level.
REQ-008 goal2  in  1  goal flag for player-2 side, level.
REQ-009 ball1_x, ball1_y  out  10 each  player-1 paddle centre, registered.
REQ-010 ball2_x, ball2_y  out  10 each  player-2 paddle centre, registered.
REQ-011 frozen  out  1  high while state is FREEZE.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer; only synchronized values are used.
REQ-013 Movement SHALL occur only on cycles where tick is true; position outputs change at most once per tick, one clk after the tick cycle.
REQ-014 Per axis: up decrements y, down increments y, left decrements x, right increments x, each by step (default 4).
REQ-015 Opposing buttons on the same axis both pressed SHALL produce no motion on that axis; the other axis is unaffected.
REQ-016 Bounds: P1 x in [249,449], P2 x in [479,679], both y in [126,416]; any computed position outside SHALL be clamped to the violated bound, never wrapped.
REQ-017 Arithmetic SHALL use 11-bit signed intermediates so decrements below 0 cannot wrap before clamping.
REQ-018 Home positions: P1 (289,271), P2 (639,271).
REQ-019 States: PLAY, FREEZE.
REQ-020 goal_evt = rising edge of (goal1|goal2), detected per clk, independent of tick.
REQ-021 PLAY -> FREEZE on goal_evt: both paddles set to home on the next clk, freeze counter loaded with 31.
REQ-022 In FREEZE, buttons SHALL be ignored; counter decrements on each tick; at tick with counter==0, go to PLAY (32 ticks total frozen).
REQ-023 goal_evt while in FREEZE SHALL reset both paddles to home and reload the counter to 31.
REQ-024 goal_evt and tick in the same cycle: goal handling wins; no movement applied that cycle.
REQ-025 goal1 and goal2 both rising in the same cycle SHALL be a single goal_evt.

Reset
REQ-026 clr high SHALL immediately force: paddles at home, state PLAY, frozen=0, freeze counter 0, synchronizers and edge detector 0, hold counters 0.
REQ-027 clr asserted mid-FREEZE or mid-movement SHALL abandon the operation with no residual effect after release.

Configuration
REQ-028 Macro PADDLE_ACCEL_EN: when defined, step per paddle per axis starts at 2 on first pressed tick, increases by 1 every 8 consecutive pressed ticks on that axis, saturates at 8, returns to 2 when the axis is released or entering FREEZE.
REQ-029 Without PADDLE_ACCEL_EN, step SHALL be a constant 4 and no hold counters are synthesized.

Verification
REQ-030 Reset, then btn1=right held for 10 ticks (no accel) -> ball1_x=329, ball1_y=271, ball2 unchanged at (639,271).
REQ-031 btn2=left held for 60 ticks (no accel) -> ball2_x clamps at 479 and stays; never below 479.
REQ-032 btn1=up+down held 5 ticks -> ball1_y stays 271; with up+down+right -> only x moves (+4/tick).
REQ-033 Move P1 to (329,271), pulse goal2 one clk coincident with a tick -> next clk both paddles home, frozen=1; buttons ignored for 32 ticks; frozen=0 after 32nd tick.
REQ-034 Assert clr mid-FREEZE (tick 10) -> frozen=0 and paddles home immediately; button press after release moves on next tick.
REQ-035 With PADDLE_ACCEL_EN, btn1=down held 17 ticks -> y deltas 2x8, 3x8, 4x1 -> ball1_y=271+44=315.
